// File: rtl/pwm_dac.sv
// pwm_dac -- turns each DDS sine sample into one fixed-period PWM waveform on a
// single pin that drives the board RC filter.
//
// Samples come in over a valid/ready handshake and land in a one-entry shadow
// register. The shadow register is copied into the active duty only when a
// period wraps, so the duty never changes part-way through a period.
//
// Ports:
//   src_clk      in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   ena          in   run enable; low freezes the counter and holds pwm_out low
//   sample       in   DATA_W-bit duty value from the DDS
//   sample_valid in   sample is valid this cycle
//   sample_ready out  shadow register is empty
//   pwm_out      out  registered PWM output
//   period_start out  one-cycle pulse on the first cycle of each period (cnt==0)
//   underrun     out  one-cycle pulse when a period starts with no new sample

module pwm_dac #(
  parameter int DATA_W     = 7,
  parameter int PERIOD     = 128,
  parameter int RESET_DUTY = 64,
  parameter int INVERT     = 0
) (
  input  logic              src_clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [DATA_W-1:0] sample,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              pwm_out,
  output logic              period_start,
  output logic              underrun
);

  localparam int CNT_W = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  // The compare runs at the wider of the two widths, so a duty of PERIOD or
  // more is never truncated and simply saturates to constant high.
  localparam int CMP_W = (CNT_W > DATA_W) ? CNT_W : DATA_W;

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PERIOD - 1);
  localparam logic [DATA_W-1:0] DUTY_RST = DATA_W'(RESET_DUTY);
  localparam logic              INV      = (INVERT != 0);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] active_q, active_d;
  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic              shadow_full_q, shadow_full_d;
  logic              pwm_q, pwm_d;
  logic              period_start_q, period_start_d;
  logic              underrun_q, underrun_d;

  logic              accept;
  logic              wrap;
  logic              pwm_raw;
  logic [CMP_W-1:0]  cnt_ext;
  logic [CMP_W-1:0]  active_ext;

  always_comb begin
    cnt_d          = cnt_q;
    active_d       = active_q;
    shadow_d       = shadow_q;
    shadow_full_d  = shadow_full_q;
    pwm_d          = 1'b0;
    period_start_d = 1'b0;
    underrun_d     = 1'b0;

    accept     = sample_valid && !shadow_full_q;
    wrap       = ena && (cnt_q == CNT_LAST);
    cnt_ext    = CMP_W'(cnt_q);
    active_ext = CMP_W'(active_q);
    pwm_raw    = (cnt_ext < active_ext);

    if (accept) begin
      shadow_d      = sample;
      shadow_full_d = 1'b1;
    end

    if (ena) begin
      cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
      pwm_d = pwm_raw ^ INV;
    end

    // The transfer decision looks at shadow_full before this edge. When the
    // shadow was empty, a sample accepted on this same edge stays in the
    // shadow until the next wrap and the period still reports an underrun.
    if (wrap) begin
      period_start_d = 1'b1;
      if (shadow_full_q) begin
        active_d      = shadow_q;
        shadow_full_d = 1'b0;
      end else begin
        underrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge src_clk) begin
    if (rst) begin
      cnt_q          <= '0;
      active_q       <= DUTY_RST;
      shadow_q       <= DUTY_RST;
      shadow_full_q  <= 1'b0;
      pwm_q          <= 1'b0;
      period_start_q <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      active_q       <= active_d;
      shadow_q       <= shadow_d;
      shadow_full_q  <= shadow_full_d;
      pwm_q          <= pwm_d;
      period_start_q <= period_start_d;
      underrun_q     <= underrun_d;
    end
  end

  assign sample_ready = !shadow_full_q;
  assign pwm_out      = pwm_q;
  assign period_start = period_start_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_pwm_dac.sv
module tb_pwm_dac;

  logic       src_clk;
  logic       rst;
  logic       ena;
  logic [6:0] sample;
  logic       sample_valid;
  logic       sample_ready;
  logic       pwm_out;
  logic       period_start;
  logic       underrun;

  logic       b_rst;
  logic       b_ena;
  logic [6:0] b_sample;
  logic       b_valid;
  logic       b_ready;
  logic       b_pwm;
  logic       b_ps;
  logic       b_ur;

  int errors = 0;
  int checks = 0;
  int h_acc  = 0;
  int ps_acc = 0;
  int ur_acc = 0;

  pwm_dac dut (
    .src_clk      (src_clk),
    .rst          (rst),
    .ena          (ena),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .underrun     (underrun)
  );

  pwm_dac #(.PERIOD(64)) dut_p64 (
    .src_clk      (src_clk),
    .rst          (b_rst),
    .ena          (b_ena),
    .sample       (b_sample),
    .sample_valid (b_valid),
    .sample_ready (b_ready),
    .pwm_out      (b_pwm),
    .period_start (b_ps),
    .underrun     (b_ur)
  );

  initial src_clk = 1'b0;
  always #5 src_clk = ~src_clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge src_clk);
    #1;
    if (pwm_out)      h_acc++;
    if (period_start) ps_acc++;
    if (underrun)     ur_acc++;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic clr();
    h_acc  = 0;
    ps_acc = 0;
    ur_acc = 0;
  endtask

  int bp_vals [3] = '{10, 20, 30};
  int exp_h   [4] = '{32, 10, 20, 30};
  int exp_acc [4] = '{1, 1, 1, 0};
  int exp_ur  [4] = '{0, 0, 0, 1};
  int idx;
  int acc_n;
  int bh, bps, bur;
  logic took;

  initial begin
    rst = 1'b1; ena = 1'b0; sample = '0; sample_valid = 1'b0;
    b_rst = 1'b1; b_ena = 1'b0; b_sample = '0; b_valid = 1'b0;

    // Reset state
    run(3);
    chk("rst_pwm", pwm_out, 0);
    chk("rst_ps", period_start, 0);
    chk("rst_ur", underrun, 0);
    chk("rst_ready", sample_ready, 1);

    // Free-running at reset duty 64, no samples
    rst = 1'b0; ena = 1'b1;
    clr(); run(128);
    chk("p1_high", h_acc, 64);
    chk("p1_ps_last", period_start, 1);
    chk("p1_ur", ur_acc, 1);
    chk("p1_ready", sample_ready, 1);
    clr(); run(128);
    chk("p2_high", h_acc, 64);
    chk("p2_ur", ur_acc, 1);

    // Single sample mid-period
    clr(); run(40);
    sample = 7'd32; sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    chk("single_ready_drop", sample_ready, 0);
    run(87);
    chk("single_cur_high", h_acc, 64);
    chk("single_cur_ur", ur_acc, 0);
    chk("single_cur_ps", ps_acc, 1);
    chk("single_ready_back", sample_ready, 1);
    clr(); run(128);
    chk("single_next_high", h_acc, 32);
    chk("single_next_ur", ur_acc, 1);

    // Back-pressure: one accept per period
    idx = 0; sample = 7'(bp_vals[0]); sample_valid = 1'b1;
    for (int p = 0; p < 4; p++) begin
      clr(); acc_n = 0;
      repeat (128) begin
        took = sample_valid && sample_ready;
        tick();
        if (took) begin
          acc_n++; idx++;
          if (idx < 3) sample = 7'(bp_vals[idx]);
          else sample_valid = 1'b0;
        end
      end
      chk($sformatf("bp_high_%0d", p), h_acc, exp_h[p]);
      chk($sformatf("bp_acc_%0d", p), acc_n, exp_acc[p]);
      chk($sformatf("bp_ur_%0d", p), ur_acc, exp_ur[p]);
    end
    chk("bp_total", idx, 3);

    // Wrap collision: accept on the cnt==127 edge with the shadow empty
    clr(); run(127);
    chk("wc_ready_pre", sample_ready, 1);
    sample = 7'd100; sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    chk("wc_ur", underrun, 1);
    chk("wc_ps", period_start, 1);
    chk("wc_ready_post", sample_ready, 0);
    clr(); run(128);
    chk("wc_old_high", h_acc, 30);
    chk("wc_old_ur", ur_acc, 0);
    clr(); run(128);
    chk("wc_new_high", h_acc, 100);
    chk("wc_new_ur", ur_acc, 1);

    // Extremes: duty 0 then duty 127
    sample = 7'd0; sample_valid = 1'b1;
    clr(); tick();
    sample_valid = 1'b0;
    run(127);
    chk("ext_pre_high", h_acc, 100);
    sample = 7'd127; sample_valid = 1'b1;
    clr(); tick();
    sample_valid = 1'b0;
    run(127);
    chk("ext_zero_high", h_acc, 0);
    clr(); run(126);
    tick();
    chk("ext_127_cnt126", pwm_out, 1);
    tick();
    chk("ext_127_cnt127", pwm_out, 0);
    chk("ext_127_high", h_acc, 127);

    // Enable drop at cnt=50 for 20 cycles
    clr(); run(50);
    chk("ena_pre_high", h_acc, 50);
    ena = 1'b0;
    clr(); run(20);
    chk("ena_off_high", h_acc, 0);
    chk("ena_off_ps", ps_acc, 0);
    chk("ena_off_ur", ur_acc, 0);
    chk("ena_off_pwm", pwm_out, 0);
    ena = 1'b1;
    clr(); run(77);
    chk("ena_resume_ps", ps_acc, 0);
    chk("ena_resume_high", h_acc, 77);
    tick();
    chk("ena_resume_wrap", period_start, 1);
    chk("ena_resume_last", pwm_out, 0);

    // Reset at cnt=70 with the shadow full
    sample = 7'd5; sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    run(69);
    chk("mr_ready_full", sample_ready, 0);
    chk("mr_pwm_pre", pwm_out, 1);
    rst = 1'b1;
    tick();
    chk("mr_pwm", pwm_out, 0);
    chk("mr_ps", period_start, 0);
    chk("mr_ur", underrun, 0);
    chk("mr_ready", sample_ready, 1);
    rst = 1'b0;
    clr(); run(128);
    chk("mr_after_high", h_acc, 64);
    chk("mr_after_ur", ur_acc, 1);
    chk("mr_after_ps", ps_acc, 1);

    // PERIOD=64 instance: duties >= 64 saturate to constant high
    b_rst = 1'b0; b_ena = 1'b1; b_sample = 7'd100; b_valid = 1'b1;
    bh = 0; bps = 0; bur = 0;
    for (int i = 0; i < 64; i++) begin
      @(posedge src_clk); #1;
      b_valid = 1'b0;
      if (b_pwm) bh++;
      if (b_ps)  bps++;
      if (b_ur)  bur++;
    end
    chk("p64_first_high", bh, 64);
    chk("p64_first_ps", bps, 1);
    chk("p64_first_ur", bur, 0);
    bh = 0; bps = 0; bur = 0;
    for (int i = 0; i < 64; i++) begin
      @(posedge src_clk); #1;
      if (b_pwm) bh++;
      if (b_ps)  bps++;
      if (b_ur)  bur++;
    end
    chk("p64_sat_high", bh, 64);
    chk("p64_sat_ur", bur, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
